int_ctrl16: RTL and testbench

INT_CTRL16 -- requirements
Module: int_ctrl16

---
 rtl/int_ctrl_pkg.sv | 14 +
 rtl/prio16_4.sv | 19 +
 rtl/int_ctrl16.sv | 102 ++++++++++
 tb/tb_int_ctrl16.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants and state encodings for the 16-line fixed-priority interrupt controller.
package int_ctrl_pkg;
   localparam int N_IRQ = 16;
   localparam int VEC_W = 4;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ASSERT  = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   function automatic logic [N_IRQ-1:0] onehot(input logic [VEC_W-1:0] idx);
      onehot      = '0;
      onehot[idx] = 1'b1;
   endfunction
endpackage

// File: rtl/prio16_4.sv
// Fixed-priority encoder: index of the highest set request bit, plus a valid flag.
module prio16_4
   import int_ctrl_pkg::*;
(
   input  logic [N_IRQ-1:0] i_req,
   output logic [VEC_W-1:0] o_idx,
   output logic             o_vld
);

   always_comb begin
      o_idx = '0;
      o_vld = |i_req;
      // Ascending scan so the last (highest) set bit overwrites lower ones.
      for (int i = 0; i < N_IRQ; i++) begin
         if (i_req[i]) o_idx = VEC_W'(i);
      end
   end

endmodule

// File: rtl/int_ctrl16.sv
// 16-line interrupt controller: edge-detected requests, maskable, fixed priority,
// single-level INT/INTA/EOI handshake without nesting.
module int_ctrl16
   import int_ctrl_pkg::*;
(
   input  logic             CP,
   input  logic             nCR,
   input  logic [N_IRQ-1:0] IR,
   input  logic             EN,
   input  logic             MASK_WE,
   input  logic [N_IRQ-1:0] MASK_D,
   input  logic             INTA,
   input  logic             EOI,
   output logic             INT,
   output logic [VEC_W-1:0] VEC,
   output logic             GS,
   output logic [N_IRQ-1:0] IRR,
   output logic [N_IRQ-1:0] ISR,
   output logic [N_IRQ-1:0] MASK
);

   logic [1:0]       r_state;
   logic             r_int;
   logic [VEC_W-1:0] r_vec;
   logic [N_IRQ-1:0] r_irr;
   logic [N_IRQ-1:0] r_isr;
   logic [N_IRQ-1:0] r_mask;
   logic [N_IRQ-1:0] r_ir_d;

   logic [N_IRQ-1:0] w_rise;
   logic [N_IRQ-1:0] w_elig;
   logic [N_IRQ-1:0] w_clr;
   logic [VEC_W-1:0] w_idx;
   logic             w_vld;
   logic             w_grant;

   assign w_rise  = IR & ~r_ir_d;
   assign w_elig  = r_irr & ~r_mask;
   // Losing EN or all eligible requests in the same cycle as INTA cancels the grant.
   assign w_grant = (r_state == ASSERT) && INTA && EN && w_vld;
   assign w_clr   = w_grant ? onehot(w_idx) : '0;

   prio16_4 u_prio (
      .i_req (w_elig),
      .o_idx (w_idx),
      .o_vld (w_vld)
   );

   always_ff @(posedge CP or negedge nCR) begin
      if (!nCR) begin
         r_state <= IDLE;
         r_int   <= 1'b0;
         r_vec   <= '0;
         r_irr   <= '0;
         r_isr   <= '0;
         r_mask  <= '1;
         r_ir_d  <= '0;
      end else begin
         r_ir_d <= IR;
         // A fresh edge on the line being granted wins over the grant-clear.
         r_irr  <= (r_irr & ~w_clr) | w_rise;
         if (MASK_WE) r_mask <= MASK_D;
         case (r_state)
            IDLE: begin
               if (EN && w_vld) begin
                  r_state <= ASSERT;
                  r_int   <= 1'b1;
               end
            end
            ASSERT: begin
               if (w_grant) begin
                  r_state <= SERVICE;
                  r_int   <= 1'b0;
                  r_vec   <= w_idx;
                  r_isr   <= r_isr | onehot(w_idx);
               end else if (!EN || !w_vld) begin
                  r_state <= IDLE;
                  r_int   <= 1'b0;
               end
            end
            SERVICE: begin
               if (EOI) begin
                  r_state <= IDLE;
                  r_isr   <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_int   <= 1'b0;
            end
         endcase
      end
   end

   assign INT  = r_int;
   assign VEC  = r_vec;
   assign GS   = w_vld;
   assign IRR  = r_irr;
   assign ISR  = r_isr;
   assign MASK = r_mask;

endmodule

// File: tb/tb_int_ctrl16.sv
// Bench for int_ctrl16: directed scenarios plus random traffic against a behavioural model.
module tb_int_ctrl16;

   logic        CP = 1'b0;
   logic        nCR;
   logic [15:0] IR;
   logic        EN;
   logic        MASK_WE;
   logic [15:0] MASK_D;
   logic        INTA;
   logic        EOI;
   logic        INT;
   logic [3:0]  VEC;
   logic        GS;
   logic [15:0] IRR;
   logic [15:0] ISR;
   logic [15:0] MASK;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: pending/in-service sets plus two flags for the handshake.
   logic [15:0] m_irr, m_isr, m_mask, m_prev;
   logic [3:0]  m_vec;
   bit          m_int, m_serv;

   int_ctrl16 dut (
      .CP(CP), .nCR(nCR), .IR(IR), .EN(EN), .MASK_WE(MASK_WE), .MASK_D(MASK_D),
      .INTA(INTA), .EOI(EOI), .INT(INT), .VEC(VEC), .GS(GS),
      .IRR(IRR), .ISR(ISR), .MASK(MASK)
   );

   always #5 CP = ~CP;

   function automatic int highest(input logic [15:0] v);
      int r;
      r = -1;
      for (int i = 0; i < 16; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_irr  = '0;
      m_isr  = '0;
      m_mask = 16'hFFFF;
      m_prev = '0;
      m_vec  = '0;
      m_int  = 0;
      m_serv = 0;
   endtask

   // Advance one clock: evaluate the model on the current inputs, take the edge, settle.
   task automatic step();
      logic [15:0] elig, edges, clr, n_isr;
      logic [3:0]  n_vec;
      bit          n_int, n_serv;
      int          top;
      elig   = m_irr & ~m_mask;
      top    = highest(elig);
      edges  = IR & ~m_prev;
      clr    = '0;
      n_isr  = m_isr;
      n_vec  = m_vec;
      n_int  = m_int;
      n_serv = m_serv;
      if (m_serv) begin
         if (EOI) begin
            n_serv = 0;
            n_isr  = '0;
         end
      end else if (m_int) begin
         if (!EN || top < 0) begin
            n_int = 0;
         end else if (INTA) begin
            n_vec  = 4'(top);
            clr    = 16'h1 << top;
            n_isr  = clr;
            n_int  = 0;
            n_serv = 1;
         end
      end else if (EN && top >= 0) begin
         n_int = 1;
      end
      @(posedge CP);
      m_irr  = (m_irr & ~clr) | edges;
      if (MASK_WE) m_mask = MASK_D;
      m_isr  = n_isr;
      m_vec  = n_vec;
      m_int  = n_int;
      m_serv = n_serv;
      m_prev = IR;
      #1;
   endtask

   task automatic do_reset();
      IR = '0; EN = 1'b1; MASK_WE = 1'b0; MASK_D = '0; INTA = 1'b0; EOI = 1'b0;
      nCR = 1'b0;
      model_reset();
      #4;
      nCR = 1'b1;
   endtask

   task automatic set_mask(input logic [15:0] v);
      MASK_WE = 1'b1;
      MASK_D  = v;
      step();
      MASK_WE = 1'b0;
   endtask

   task automatic pulse_inta();
      INTA = 1'b1; step(); INTA = 1'b0;
   endtask

   task automatic pulse_eoi();
      EOI = 1'b1; step(); EOI = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (INT !== 1'b0)      begin n_fail++; $display("FAIL rst_int got=%b want=0", INT); end
      n_checks++; if (VEC !== 4'd0)      begin n_fail++; $display("FAIL rst_vec got=%0d want=0", VEC); end
      n_checks++; if (IRR !== 16'h0)     begin n_fail++; $display("FAIL rst_irr got=%h want=0000", IRR); end
      n_checks++; if (ISR !== 16'h0)     begin n_fail++; $display("FAIL rst_isr got=%h want=0000", ISR); end
      n_checks++; if (MASK !== 16'hFFFF) begin n_fail++; $display("FAIL rst_mask got=%h want=ffff", MASK); end
      n_checks++; if (GS !== 1'b0)       begin n_fail++; $display("FAIL rst_gs got=%b want=0", GS); end
   endtask

   task automatic test_basic();
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0008; step();
      n_checks++; if (IRR !== 16'h0008) begin n_fail++; $display("FAIL basic_irr got=%h want=0008", IRR); end
      n_checks++; if (INT !== 1'b0)     begin n_fail++; $display("FAIL basic_int0 got=%b want=0", INT); end
      step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL basic_int1 got=%b want=1", INT); end
      pulse_inta();
      n_checks++; if (VEC !== 4'd3)     begin n_fail++; $display("FAIL basic_vec got=%0d want=3", VEC); end
      n_checks++; if (ISR !== 16'h0008) begin n_fail++; $display("FAIL basic_isr got=%h want=0008", ISR); end
      n_checks++; if (IRR !== 16'h0000) begin n_fail++; $display("FAIL basic_irr_clr got=%h want=0000", IRR); end
      n_checks++; if (INT !== 1'b0)     begin n_fail++; $display("FAIL basic_int_drop got=%b want=0", INT); end
      pulse_eoi();
      n_checks++; if (ISR !== 16'h0000) begin n_fail++; $display("FAIL basic_eoi_isr got=%h want=0000", ISR); end
      IR = '0; step();
      n_checks++; if (INT !== 1'b0)     begin n_fail++; $display("FAIL basic_idle_int got=%b want=0", INT); end
   endtask

   task automatic test_priority();
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0204; step(); step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL prio_int got=%b want=1", INT); end
      pulse_inta();
      n_checks++; if (VEC !== 4'd9)     begin n_fail++; $display("FAIL prio_vec9 got=%0d want=9", VEC); end
      n_checks++; if (IRR !== 16'h0004) begin n_fail++; $display("FAIL prio_irr got=%h want=0004", IRR); end
      pulse_eoi();
      step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL prio_reassert got=%b want=1", INT); end
      pulse_inta();
      n_checks++; if (VEC !== 4'd2)     begin n_fail++; $display("FAIL prio_vec2 got=%0d want=2", VEC); end
      pulse_eoi();
      IR = '0; step();
   endtask

   task automatic test_mask();
      do_reset();
      IR = 16'h0020; step();
      n_checks++; if (IRR !== 16'h0020) begin n_fail++; $display("FAIL mask_irr got=%h want=0020", IRR); end
      n_checks++; if (GS !== 1'b0)      begin n_fail++; $display("FAIL mask_gs0 got=%b want=0", GS); end
      step();
      n_checks++; if (INT !== 1'b0)     begin n_fail++; $display("FAIL mask_int0 got=%b want=0", INT); end
      set_mask(16'hFFDF);
      n_checks++; if (GS !== 1'b1)      begin n_fail++; $display("FAIL mask_gs1 got=%b want=1", GS); end
      step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL mask_int1 got=%b want=1", INT); end
      pulse_inta(); pulse_eoi();
      IR = '0; step();
   endtask

   task automatic test_preempt();
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0002; step(); step();
      IR = 16'h4002; step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL pre_int got=%b want=1", INT); end
      pulse_inta();
      n_checks++; if (VEC !== 4'd14)    begin n_fail++; $display("FAIL pre_vec got=%0d want=14", VEC); end
      n_checks++; if (IRR !== 16'h0002) begin n_fail++; $display("FAIL pre_irr got=%h want=0002", IRR); end
      pulse_eoi(); step(); pulse_inta(); pulse_eoi();
      IR = '0; step();
   endtask

   task automatic test_enable();
      logic [3:0] v_before;
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0010; step(); step();
      EN = 1'b0; step();
      n_checks++; if (INT !== 1'b0)     begin n_fail++; $display("FAIL en_drop got=%b want=0", INT); end
      n_checks++; if (IRR !== 16'h0010) begin n_fail++; $display("FAIL en_irr got=%h want=0010", IRR); end
      EN = 1'b1; step();
      n_checks++; if (INT !== 1'b1)     begin n_fail++; $display("FAIL en_restore got=%b want=1", INT); end
      EN = 1'b0; step();
      v_before = VEC;
      pulse_inta(); pulse_eoi();
      n_checks++; if (INT !== 1'b0 || ISR !== 16'h0 || IRR !== 16'h0010 || VEC !== v_before)
         begin n_fail++; $display("FAIL en_idle_inta got=%b/%h/%h/%0d want=0/0000/0010/%0d", INT, ISR, IRR, VEC, v_before); end
      EN = 1'b1; step(); pulse_inta(); pulse_eoi();
      IR = '0; step();
   endtask

   task automatic test_same_edge();
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0080; step();
      IR = 16'h0000; step();
      IR = 16'h0080; INTA = 1'b1; step(); INTA = 1'b0;
      n_checks++; if (VEC !== 4'd7)     begin n_fail++; $display("FAIL edge_vec got=%0d want=7", VEC); end
      n_checks++; if (IRR !== 16'h0080) begin n_fail++; $display("FAIL edge_irr got=%h want=0080", IRR); end
      IR = 16'h8080; step();
      n_checks++; if (IRR !== 16'h8080 || INT !== 1'b0 || ISR !== 16'h0080)
         begin n_fail++; $display("FAIL nonest got=%h/%b/%h want=8080/0/0080", IRR, INT, ISR); end
      pulse_eoi(); step();
      INTA = 1'b1; EOI = 1'b1; step(); INTA = 1'b0; EOI = 1'b0;
      n_checks++; if (VEC !== 4'd15 || ISR !== 16'h8000 || INT !== 1'b0)
         begin n_fail++; $display("FAIL inta_eoi got=%0d/%h/%b want=15/8000/0", VEC, ISR, INT); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_mask(16'h0000);
      IR = 16'h0040; step(); step(); pulse_inta();
      #3; nCR = 1'b0; model_reset();
      #1;
      n_checks++; if (INT !== 1'b0 || VEC !== 4'd0 || IRR !== 16'h0 || ISR !== 16'h0 || MASK !== 16'hFFFF || GS !== 1'b0)
         begin n_fail++; $display("FAIL async_rst got=%b/%0d/%h/%h/%h/%b want=0/0/0000/0000/ffff/0", INT, VEC, IRR, ISR, MASK, GS); end
      IR = 16'h0101;
      #2; nCR = 1'b1;
      step();
      n_checks++; if (IRR !== 16'h0101 || INT !== 1'b0)
         begin n_fail++; $display("FAIL rel_edge got=%h/%b want=0101/0", IRR, INT); end
      IR = '0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         IR      = IR ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
         EN      = ($urandom_range(0, 9) != 0);
         INTA    = ($urandom_range(0, 2) == 0);
         EOI     = ($urandom_range(0, 3) == 0);
         MASK_WE = ($urandom_range(0, 19) == 0);
         MASK_D  = 16'($urandom) & 16'($urandom);
         step();
         n_checks++; if (IRR !== m_irr)   begin n_fail++; $display("FAIL rnd_irr c=%0d got=%h want=%h", c, IRR, m_irr); end
         n_checks++; if (ISR !== m_isr)   begin n_fail++; $display("FAIL rnd_isr c=%0d got=%h want=%h", c, ISR, m_isr); end
         n_checks++; if (MASK !== m_mask) begin n_fail++; $display("FAIL rnd_mask c=%0d got=%h want=%h", c, MASK, m_mask); end
         n_checks++; if (INT !== m_int)   begin n_fail++; $display("FAIL rnd_int c=%0d got=%b want=%b", c, INT, m_int); end
         n_checks++; if (VEC !== m_vec)   begin n_fail++; $display("FAIL rnd_vec c=%0d got=%0d want=%0d", c, VEC, m_vec); end
         n_checks++; if (GS !== |(m_irr & ~m_mask))
            begin n_fail++; $display("FAIL rnd_gs c=%0d got=%b want=%b", c, GS, |(m_irr & ~m_mask)); end
      end
      INTA = 1'b0; EOI = 1'b0; MASK_WE = 1'b0;
   endtask

   initial begin
      IR = '0; EN = 1'b0; MASK_WE = 1'b0; MASK_D = '0; INTA = 1'b0; EOI = 1'b0; nCR = 1'b0;
      model_reset();
      @(posedge CP); #1;
      test_reset();
      test_basic();
      test_priority();
      test_mask();
      test_preempt();
      test_enable();
      test_same_edge();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
